// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - bus bundle for the register-file write arbiter
//
// Groups every non-clock/reset signal of regfile_write_arbiter.
//   master : source side (pipeline + long-latency unit), consumes the write port
//   slave  : the arbiter itself
// Signals:
//   stall                   pipeline stall, blocks register-file writes
//   wb_we/wb_rd/wb_data     pipeline writeback
//   lu_valid/lu_ready       long-latency handshake
//   lu_rd/lu_data           long-latency destination and result
//   WE3/A3/WD3              registered register-file write port
//   pending                 per-register "live buffered write" mask
//   fifo_count              occupied buffer slots, live or killed
interface regfile_write_arbiter_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_COUNT      = 1 << REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 4
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                      stall;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [REG_DATA_WIDTH-1:0] wb_data;
  logic                      lu_valid;
  logic                      lu_ready;
  logic [REG_ADDR_WIDTH-1:0] lu_rd;
  logic [REG_DATA_WIDTH-1:0] lu_data;
  logic                      WE3;
  logic [REG_ADDR_WIDTH-1:0] A3;
  logic [REG_DATA_WIDTH-1:0] WD3;
  logic [REG_COUNT-1:0]      pending;
  logic [COUNT_W-1:0]        fifo_count;

  modport master (
    output stall, wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, WE3, A3, WD3, pending, fifo_count
  );

  modport slave (
    input  stall, wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, WE3, A3, WD3, pending, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - single write port arbiter for the pipeline register file
//
// Merges pipeline writeback and buffered long-latency results into one
// registered write per cycle, keeping write-after-write order.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  regfile_write_arbiter_if.slave (see interface for signal list)
module regfile_write_arbiter #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_COUNT      = 1 << REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [REG_ADDR_WIDTH-1:0] ent_rd   [FIFO_DEPTH];
  logic [REG_DATA_WIDTH-1:0] ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     ent_live;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [COUNT_W-1:0]        count;

  logic                      wb_fire;
  logic                      push;
  logic                      pop;
  logic [REG_COUNT-1:0]      pend_c;

  // Readiness looks only at the registered count, so a full buffer never
  // accepts even when it is being drained in the same cycle.
  assign bus.lu_ready   = (count < COUNT_W'(FIFO_DEPTH));
  assign bus.fifo_count = count;

  assign wb_fire = !bus.stall && bus.wb_we && (bus.wb_rd != '0);
  // Results aimed at x0 complete the handshake but are never stored.
  assign push    = bus.lu_valid && bus.lu_ready && (bus.lu_rd != '0);
  assign pop     = !bus.stall && !wb_fire && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= bus.lu_rd;
      ent_data[wr_ptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_live <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      // A pipeline write is always newer than anything buffered, so older
      // buffered writes to the same register must never reach the file.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (wb_fire && (ent_rd[i] == bus.wb_rd)) begin
          ent_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_live[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      // Push slot is never the popped slot: push needs count<DEPTH and pop
      // needs count>0, so the pointers differ whenever both happen.
      if (push) begin
        ent_live[wr_ptr] <= !(wb_fire && (bus.lu_rd == bus.wb_rd));
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + COUNT_W'(1);
      end else if (pop && !push) begin
        count <= count - COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.WE3 <= 1'b0;
      bus.A3  <= '0;
      bus.WD3 <= '0;
    end else if (bus.stall) begin
      bus.WE3 <= 1'b0;
    end else if (wb_fire) begin
      bus.WE3 <= 1'b1;
      bus.A3  <= bus.wb_rd;
      bus.WD3 <= bus.wb_data;
    end else if (pop) begin
      // A killed head is dropped silently; address/data keep their old value.
      bus.WE3 <= ent_live[rd_ptr];
      if (ent_live[rd_ptr]) begin
        bus.A3  <= ent_rd[rd_ptr];
        bus.WD3 <= ent_data[rd_ptr];
      end
    end else begin
      bus.WE3 <= 1'b0;
    end
  end

  always_comb begin
    pend_c = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_live[i]) begin
        pend_c[ent_rd[i]] = 1'b1;
      end
    end
  end

  assign bus.pending = {pend_c[REG_COUNT-1:1], 1'b0};
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writer side of the pipeline register file: owns the single write port (WE3/A3/WD3).
- Merges two write sources into one registered write per cycle:
  - the in-order pipeline writeback stage;
  - a long-latency unit (mul/div, or a late load) with a valid/ready handshake.
- Long-latency results are buffered in a small FIFO.
- Enforces WAW ordering and exports a per-register pending mask for hazard detection.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- REG_DATA_WIDTH, 32, register data width.
- REG_COUNT, 1<<REG_ADDR_WIDTH, number of architectural registers.
- FIFO_DEPTH, 4, long-latency buffer entries; power of two, >=2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  pipeline stall; blocks all register-file writes.
- wb_we  in  1  pipeline writeback enable.
- wb_rd  in  REG_ADDR_WIDTH  pipeline destination register.
- wb_data  in  REG_DATA_WIDTH  pipeline writeback data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  buffer can accept a result.
- lu_rd  in  REG_ADDR_WIDTH  long-latency destination register.
- lu_data  in  REG_DATA_WIDTH  long-latency result data.
- WE3  out  1  register-file write enable (registered).
- A3  out  REG_ADDR_WIDTH  register-file write address (registered).
- WD3  out  REG_DATA_WIDTH  register-file write data (registered).
- pending  out  REG_COUNT  bit r set iff a live FIFO entry targets x r.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of occupied entries, live or killed.

Behaviour:
- Reset, on the rising edge with rst=1:
  - WE3=0, A3=0, WD3=0;
  - FIFO empty, all entries dead;
  - pending=0, fifo_count=0.
- lu_ready = (fifo_count < FIFO_DEPTH); depends on registered count only, so no push into a full FIFO even when a pop occurs in the same cycle.
- Push condition: lu_valid && lu_ready.
  - lu_rd==0: handshake completes, nothing stored, count unchanged.
- Per-cycle write selection, in priority order:
  1. stall=1: WE3<=0; no pop; pushes still allowed.
  2. wb_we && wb_rd!=0: WE3<=1, A3<=wb_rd, WD3<=wb_data; no pop.
  3. FIFO non-empty, head live: WE3<=1, A3<=head.rd, WD3<=head.data; pop head.
  4. FIFO non-empty, head killed: pop head; WE3<=0.
  5. Otherwise: WE3<=0; A3 and WD3 hold their previous values.
- At most one pop per cycle.
- Latency: a write selected in cycle N appears on WE3/A3/WD3 in cycle N+1.
- WAW kill rule: pipeline writeback is always architecturally newer than any long-latency result.
  - Applies on any cycle with wb_we && wb_rd!=0 && !stall.
  - Every live FIFO entry with rd==wb_rd is marked killed.
  - A push in the same cycle with lu_rd==wb_rd is stored already killed.
- Killed entries still occupy a slot until popped, and count in fifo_count.
- pending is combinational from FIFO contents: OR over live entries of one-hot(rd); killed and empty entries contribute nothing; bit 0 always 0.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle: count unchanged.
- rst mid-operation: buffered entries are discarded; no write issues in the reset cycle.
- lu_rd/lu_data are only sampled when the push condition holds.

Test Plan:
- Reset with lu_valid=1 held: in the cycle after rst deasserts, lu_ready=1, WE3=0, fifo_count=0, pending=0.
- Pipeline write only: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, stall=0 → next cycle WE3=1, A3=5, WD3=0xDEADBEEF. Repeat with wb_rd=0 → WE3=0.
- Buffering and drain:
  - push lu_rd=3/0x11, 4/0x22, 6/0x33 while wb_we=1 to x7 for 3 cycles → fifo_count=3, pending bits 3,4,6 set;
  - drop wb_we → writes x3=0x11, x4=0x22, x6=0x33 on three consecutive cycles, in order.
- Backpressure: FIFO_DEPTH=4, hold wb_we=1 and push 4 results → lu_ready=0 at count 4; a fifth lu_valid is not accepted until a pop frees a slot.
- WAW kill:
  - push lu_rd=9/0xAAAA, then pipeline writes x9=0xBBBB → pending[9] clears;
  - on drain, no write to x9 issues; the kill-pop cycle shows WE3=0;
  - same-cycle case: lu_rd=9 with wb_rd=9 → entry stored dead.
- Stall:
  - with 2 live entries, assert stall for 3 cycles while pushing 1 more → WE3=0 throughout, fifo_count=3;
  - release stall → 3 writes in FIFO order;
  - then assert rst with 2 entries buffered → fifo_count=0, pending=0, no writes.
